// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter.
// Register index and data widths plus the queued request bundle.
package wb_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [XLEN-1:0]      data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Long-latency result FIFO with pointer-derived occupancy.
// Exposes per-slot valid/index so readers can detect pending writes.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [REG_IDX_W-1:0]       push_index,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    output logic [REG_IDX_W-1:0]       head_index,
    output logic [XLEN-1:0]            head_data,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0]           ent_valid,
    output logic [DEPTH*REG_IDX_W-1:0] ent_index
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; occupancy masks stale slots.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= '{index: push_index, data: push_data};
    end

    assign head_index = mem[rd_ptr[AW-1:0]].index;
    assign head_data  = mem[rd_ptr[AW-1:0]].data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [AW-1:0] off;
        assign off = AW'(i) - rd_ptr[AW-1:0];
        assign ent_valid[i] = ({1'b0, off} < count);
        assign ent_index[i*REG_IDX_W +: REG_IDX_W] = mem[i].index;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline and long-latency results onto the regfile write port.
// A full FIFO always wins; otherwise the pipeline has priority.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_valid,
    input  logic [REG_IDX_W-1:0] p_index,
    input  logic [XLEN-1:0]      p_data,
    output logic                 stall,
    input  logic                 l_valid,
    output logic                 l_ready,
    input  logic [REG_IDX_W-1:0] l_index,
    input  logic [XLEN-1:0]      l_data,
    output logic                 we,
    output logic [REG_IDX_W-1:0] windex,
    output logic [XLEN-1:0]      win,
    input  logic [REG_IDX_W-1:0] rindex0,
    input  logic [REG_IDX_W-1:0] rindex1,
    output logic                 pend0,
    output logic                 pend1
);
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       issue;
    logic [REG_IDX_W-1:0]       head_index;
    logic [XLEN-1:0]            head_data;
    logic [REG_IDX_W-1:0]       sel_index;
    logic [XLEN-1:0]            sel_data;
    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH*REG_IDX_W-1:0] ent_index;

    assign l_ready = !full;
    assign push    = l_valid && !full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_index (l_index),
        .push_data  (l_data),
        .pop        (pop),
        .head_index (head_index),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_index  (ent_index)
    );

    always_comb begin
        pop       = 1'b0;
        stall     = 1'b0;
        issue     = 1'b0;
        sel_index = p_index;
        sel_data  = p_data;
        unique case (1'b1)
            full: begin
                pop       = 1'b1;
                issue     = 1'b1;
                stall     = p_valid;
                sel_index = head_index;
                sel_data  = head_data;
            end
            (!full && p_valid): begin
                issue = 1'b1;
            end
            (!full && !p_valid && !empty): begin
                pop       = 1'b1;
                issue     = 1'b1;
                sel_index = head_index;
                sel_data  = head_data;
            end
            default: ;
        endcase
    end

    // Index 0 is consumed but never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we     <= 1'b0;
            windex <= '0;
            win    <= '0;
        end else begin
            we <= issue && (sel_index != '0);
            if (issue) begin
                windex <= sel_index;
                win    <= sel_data;
            end
        end
    end

    always_comb begin
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                if (ent_index[i*REG_IDX_W +: REG_IDX_W] == rindex0 &&
                    rindex0 != '0)
                    pend0 = 1'b1;
                if (ent_index[i*REG_IDX_W +: REG_IDX_W] == rindex1 &&
                    rindex1 != '0)
                    pend1 = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench: stimulus queues expected writes, a monitor retires them.
// Combinational outputs are checked inline by the stimulus thread.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0;
    logic [4:0]  p_index = '0;
    logic [31:0] p_data = '0;
    logic        stall;
    logic        l_valid = 1'b0;
    logic        l_ready;
    logic [4:0]  l_index = '0;
    logic [31:0] l_data = '0;
    logic        we;
    logic [4:0]  windex;
    logic [31:0] win;
    logic [4:0]  rindex0 = '0;
    logic [4:0]  rindex1 = '0;
    logic        pend0;
    logic        pend1;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_index (p_index),
        .p_data  (p_data),
        .stall   (stall),
        .l_valid (l_valid),
        .l_ready (l_ready),
        .l_index (l_index),
        .l_data  (l_data),
        .we      (we),
        .windex  (windex),
        .win     (win),
        .rindex0 (rindex0),
        .rindex1 (rindex1),
        .pend0   (pend0),
        .pend1   (pend1)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_p(logic v, logic [4:0] i, logic [31:0] d);
        p_valid = v;
        p_index = i;
        p_data  = d;
    endtask

    task automatic drv_l(logic v, logic [4:0] i, logic [31:0] d);
        l_valid = v;
        l_index = i;
        l_data  = d;
    endtask

    task automatic expect_wr(logic [4:0] i, logic [31:0] d);
        sb.push_back({i, d});
    endtask

    always @(negedge clk) begin
        if (!rst && we) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got idx %0d data %0h want none",
                         windex, win);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("wr_index", 32'(windex), 32'(e[36:32]));
                chk("wr_data", win, e[31:0]);
            end
        end
    end

    initial begin
        // Reset with pipeline traffic held
        drv_p(1'b1, 5'd3, 32'h11);
        repeat (3) begin
            @(negedge clk);
            chk("rst_we", 32'(we), 32'd0);
        end
        chk("rst_windex", 32'(windex), 32'd0);
        chk("rst_win", win, 32'd0);
        expect_wr(5'd3, 32'h11);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_l_ready", 32'(l_ready), 32'd1);
        chk("rst_pend0", 32'(pend0), 32'd0);
        chk("rst_pend1", 32'(pend1), 32'd0);
        @(negedge clk);
        chk("rel_we0", 32'(we), 32'd0);
        tick();
        drv_p(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("p_latency", 32'(we), 32'd1);

        // Single long-latency result
        expect_wr(5'd5, 32'hAB);
        tick();
        drv_l(1'b1, 5'd5, 32'hAB);
        #1;
        chk("l_ready_empty", 32'(l_ready), 32'd1);
        tick();
        drv_l(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("l_lat_n1", 32'(we), 32'd0);
        tick();
        @(negedge clk);
        chk("l_lat_n2", 32'(we), 32'd1);

        // Pipeline always valid while the FIFO fills
        expect_wr(5'd10, 32'h100);
        expect_wr(5'd11, 32'h101);
        expect_wr(5'd6, 32'h66);
        expect_wr(5'd12, 32'h102);
        expect_wr(5'd7, 32'h77);
        expect_wr(5'd13, 32'h103);
        expect_wr(5'd8, 32'h88);
        tick();
        drv_p(1'b1, 5'd10, 32'h100);
        drv_l(1'b1, 5'd6, 32'h66);
        tick();
        drv_p(1'b1, 5'd11, 32'h101);
        drv_l(1'b1, 5'd7, 32'h77);
        #1;
        chk("fill_stall0", 32'(stall), 32'd0);
        tick();
        drv_p(1'b1, 5'd12, 32'h102);
        drv_l(1'b0, 5'd0, 32'h0);
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        chk("full_l_ready", 32'(l_ready), 32'd0);
        tick();
        drv_l(1'b1, 5'd8, 32'h88);
        #1;
        chk("held_stall", 32'(stall), 32'd0);
        chk("l_ready_rise", 32'(l_ready), 32'd1);
        tick();
        drv_p(1'b1, 5'd13, 32'h103);
        drv_l(1'b1, 5'd20, 32'h200);
        #1;
        chk("full2_stall", 32'(stall), 32'd1);
        chk("full2_l_ready", 32'(l_ready), 32'd0);
        tick();
        drv_l(1'b0, 5'd0, 32'h0);
        #1;
        chk("after2_stall", 32'(stall), 32'd0);
        tick();
        drv_p(1'b0, 5'd0, 32'h0);
        repeat (2) tick();

        // Index 0 suppression
        drv_p(1'b1, 5'd0, 32'hFF);
        #1;
        chk("r0_stall", 32'(stall), 32'd0);
        tick();
        drv_p(1'b0, 5'd0, 32'h0);
        drv_l(1'b1, 5'd0, 32'h55);
        @(negedge clk);
        chk("r0_p_we", 32'(we), 32'd0);
        tick();
        drv_l(1'b0, 5'd0, 32'h0);
        repeat (2) begin
            tick();
            @(negedge clk);
            chk("r0_l_we", 32'(we), 32'd0);
        end
        chk("r0_drained", 32'(l_ready), 32'd1);
        #1;
        chk("r0_no_stall", 32'(stall), 32'd0);

        // Pending-write hits
        expect_wr(5'd14, 32'h14);
        expect_wr(5'd15, 32'h15);
        expect_wr(5'd9, 32'h99);
        tick();
        drv_p(1'b1, 5'd14, 32'h14);
        drv_l(1'b1, 5'd9, 32'h99);
        rindex0 = 5'd9;
        #1;
        chk("pend0_pre", 32'(pend0), 32'd0);
        tick();
        drv_p(1'b1, 5'd15, 32'h15);
        drv_l(1'b0, 5'd0, 32'h0);
        rindex1 = 5'd0;
        #1;
        chk("pend0_hit", 32'(pend0), 32'd1);
        chk("pend1_zero", 32'(pend1), 32'd0);
        rindex1 = 5'd9;
        #1;
        chk("pend1_hit", 32'(pend1), 32'd1);
        rindex1 = 5'd4;
        #1;
        chk("pend1_miss", 32'(pend1), 32'd0);
        tick();
        drv_p(1'b0, 5'd0, 32'h0);
        #1;
        chk("pend0_popcyc", 32'(pend0), 32'd1);
        tick();
        #1;
        chk("pend0_clear", 32'(pend0), 32'd0);

        // Reset mid-operation discards queued results
        expect_wr(5'd16, 32'h16);
        tick();
        drv_p(1'b1, 5'd16, 32'h16);
        drv_l(1'b1, 5'd21, 32'h21);
        rindex0 = 5'd21;
        tick();
        drv_p(1'b1, 5'd17, 32'h17);
        drv_l(1'b0, 5'd0, 32'h0);
        #1;
        chk("mid_pend0", 32'(pend0), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_pend0", 32'(pend0), 32'd0);
        chk("mid_rst_l_ready", 32'(l_ready), 32'd1);
        drv_p(1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. Merges the in-order pipeline result stream with results from long-latency units (mult/div, cache-miss loads) onto one `we/windex/win` triple. Long-latency results are buffered in a small FIFO. Writes to register 0 are suppressed here, because the register file itself does not protect index 0. Also exposes pending-write hits so hazard logic can stall dependent reads.

## Interface
- `DEPTH`, default 2: long-latency FIFO entries; power of two, ≥2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `p_valid`  in  1: pipeline result present this cycle.
- `p_index`  in  5: pipeline destination register.
- `p_data`  in  32: pipeline result.
- `stall`  out  1: pipeline must hold `p_*` this cycle (combinational).
- `l_valid`  in  1: long-latency result offered.
- `l_ready`  out  1: FIFO accepts; transfer on `l_valid && l_ready`.
- `l_index`  in  5: long-latency destination register.
- `l_data`  in  32: long-latency result.
- `we`  out  1: register file write enable (registered).
- `windex`  out  5: write index (registered).
- `win`  out  32: write data (registered).
- `rindex0`, `rindex1`  in  5 each: decode-stage read indices.
- `pend0`, `pend1`  out  1 each: a queued FIFO entry targets the corresponding read index (combinational).

## Operation
- FIFO: `DEPTH` entries of {index, data}; rd/wr pointers of log2(DEPTH)+1 bits; `count` is derived from the pointers.
  - Full when `count == DEPTH`; empty when `count == 0`.
  - Pointers wrap modulo 2·DEPTH.
- `l_ready = (count < DEPTH)`, derived from registered state only.
  - No same-cycle push-when-full, even if a pop occurs that cycle.
- Per-cycle arbitration, first match wins:
  1. FIFO full: pop head and issue it; `stall = p_valid`.
  2. `p_valid`: issue pipeline result; `stall = 0`.
  3. FIFO non-empty: pop head and issue it.
  4. Otherwise: nothing is issued.
- Push and pop in the same cycle are legal when not full; `count` is unchanged.
- Issued entry with index 0: the entry is consumed (popped, or pipeline not stalled), but `we` is 0 next cycle.
- Long-latency results always pass through the FIFO; there is no bypass.
- `pend0`: OR over valid FIFO entries of `(entry.index == rindex0 && rindex0 != 0)`. `pend1` is computed the same way against `rindex1`. The output register is excluded, because the register file already forwards the just-written value.
- Ordering:
  - Long-latency results retire in FIFO order.
  - No ordering is enforced between the pipeline and long-latency streams; WAW avoidance is the issue logic's job, using `pend*`.

## Timing
- Reset values:
  - `we=0`, `windex=0`, `win=0`.
  - FIFO empty, so `l_ready=1`, `pend0=pend1=0`.
  - `stall=0`.
- Pipeline result latency: `p_*` presented in cycle N appears on `we/windex/win` in cycle N+1. The register file commits it at the end of N+1.
- Long-latency result latency: a result accepted in cycle N is popped no earlier than N+1 and appears on the outputs at N+2 at best.
- Starvation bound: a queued entry waits at most until the FIFO fills. A full FIFO is always drained by one entry per cycle.
- `stall` and `pend*` are combinational from registered state and current inputs. They have no dependency on `l_valid`.
- Reset asserted mid-operation: the FIFO is flushed and `we` drops asynchronously. Queued results are discarded.

## Structure
- Shared package `wb_pkg`:
  - `XLEN=32`, `REG_IDX_W=5`.
  - Typedef `wb_req_t` {index, data}.
- Sub-module `wb_fifo`: parameterised `DEPTH`, async active-high reset, push/pop/full/empty, plus a flattened entry-valid/index view for the `pend*` comparators.
- The top level holds the arbitration logic and the output register.

## Test plan
- Reset with `p_valid=1`, `p_index=3`, `p_data=0x11`: `we=0` throughout reset. After release, `we=1`, `windex=3`, `win=0x11` one cycle later.
- `l_valid` pulse with index 5, data 0xAB and no pipeline traffic: `we=1`, `windex=5`, `win=0xAB` exactly 2 cycles after acceptance.
- `p_valid` held high every cycle while pushing 2 long results (indices 6, 7): after the FIFO fills, `stall=1` for one cycle and 6 is written. Next full cycle, `stall=1` and 7 is written. Pipeline results are never lost.
- FIFO full (`DEPTH=2`) with `l_valid=1`: `l_ready=0`, no push. `l_ready` rises the cycle after the pop.
- `p_index=0`, `p_data=0xFF`: `we` stays 0, `stall=0`. Long entry with index 0 is popped without a write.
- Queue index 9, then set `rindex0=9`, `rindex1=0`: `pend0=1`, `pend1=0`. `pend0` clears the cycle after 9 is popped.
